// File: rtl/seq_ctrl.sv
// Programmable sequence controller: plays table entries 0..len for a counted
// number of passes (or until halt), with IDLE-only config writes.
module seq_ctrl #(
    parameter  int W     = 3,
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] loops,
    input  logic             halt,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [W-1:0]     cfg_data,
    input  logic             cfg_len_we,
    input  logic [AW-1:0]    cfg_len,
    output logic [W-1:0]     out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_table [DEPTH];
    logic [AW-1:0]    r_len;
    logic [AW-1:0]    r_idx, w_idx_nxt, w_idx_inc;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic             r_forever, w_forever_nxt;
    logic [W-1:0]     r_out, w_out_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_done, w_done_nxt;
    logic             r_cfg_err;
    logic             w_last, w_cfg_req, w_cfg_ok;

    assign w_idx_inc = r_idx + AW'(1);
    assign w_last    = (r_idx >= r_len);
    assign w_cfg_req = cfg_we | cfg_len_we;
    // Config is only safe when nothing is playing and no run is being launched.
    assign w_cfg_ok  = (r_state == S_IDLE) && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (halt)
                    w_state_nxt = S_IDLE;
                else if (w_last && !r_forever && r_rem <= CNT_W'(1))
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        w_idx_nxt       = r_idx;
        w_rem_nxt       = r_rem;
        w_forever_nxt   = r_forever;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_out_nxt       = '0;
                w_out_valid_nxt = 1'b0;
                if (start) begin
                    w_rem_nxt       = loops;
                    w_forever_nxt   = (loops == '0);
                    w_idx_nxt       = '0;
                    w_out_nxt       = r_table[0];
                    w_out_valid_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (halt) begin
                    w_out_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                end else if (!w_last) begin
                    w_idx_nxt = w_idx_inc;
                    w_out_nxt = r_table[w_idx_inc];
                end else if (r_forever || r_rem > CNT_W'(1)) begin
                    w_idx_nxt = '0;
                    w_out_nxt = r_table[0];
                    if (!r_forever) w_rem_nxt = r_rem - CNT_W'(1);
                end else begin
                    w_out_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                end
            end
            default: begin
                w_out_nxt       = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= '0;
            r_rem       <= '0;
            r_forever   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_idx       <= w_idx_nxt;
            r_rem       <= w_rem_nxt;
            r_forever   <= w_forever_nxt;
            r_cfg_err   <= w_cfg_req && !w_cfg_ok;
        end
    end

    // Reset contents reproduce the legacy 000,010,011,101 generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
            r_table[1] <= W'(2);
            r_table[2] <= W'(3);
            r_table[3] <= W'(5);
            r_len      <= AW'(3);
        end else if (w_cfg_ok) begin
            if (cfg_we)     r_table[cfg_addr] <= cfg_data;
            if (cfg_len_we) r_len             <= cfg_len;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: captured output streams are compared with
// an arithmetic model of the played sequence (table[c mod (len+1)], L passes).
module tb_seq_ctrl;
    localparam int W = 3, DEPTH = 8, CNT_W = 8, AW = $clog2(DEPTH);

    logic clk = 1'b0, rst = 1'b1;
    logic start = 0, halt = 0, cfg_we = 0, cfg_len_we = 0;
    logic [CNT_W-1:0] loops = '0;
    logic [AW-1:0] cfg_addr = '0, cfg_len = '0;
    logic [W-1:0] cfg_data = '0, out;
    logic out_valid, busy, done, cfg_err;

    seq_ctrl #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .loops(loops), .halt(halt),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .out(out), .out_valid(out_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [W-1:0] mdl_tbl [DEPTH];
    int mdl_len;
    logic [5:0] q_obs [$];   // {out, out_valid, done, busy} per cycle

    task automatic mdl_default();
        for (int i = 0; i < DEPTH; i++) mdl_tbl[i] = '0;
        mdl_tbl[1] = 3'b010; mdl_tbl[2] = 3'b011; mdl_tbl[3] = 3'b101;
        mdl_len = 3;
    endtask

    // Expected {out,valid,done,busy} at cycle c after the start edge.
    // L=0 means forever; h>0 means halt is seen at edge h.
    function automatic logic [5:0] exp_at(int c, int L, int h);
        int n = mdl_len + 1;
        int p = L * n;
        if (h > 0 && c >= h) return 6'b0;
        if (L == 0 || c < p) return {mdl_tbl[c % n], 3'b101};
        if (c == p) return 6'b000_011;
        return 6'b0;
    endfunction

    task automatic cap(input int L, input int n, input int h);
        q_obs.delete();
        @(negedge clk); start = 1; loops = CNT_W'(L);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            q_obs.push_back({out, out_valid, done, busy});
            start = 0;
            halt = (h > 0 && c + 1 == h);
        end
        halt = 0;
    endtask

    task automatic cfg_wr(input logic we, input int a, input int d, input logic lwe, input int l);
        @(negedge clk);
        cfg_we = we; cfg_addr = AW'(a); cfg_data = W'(d);
        cfg_len_we = lwe; cfg_len = AW'(l);
        @(negedge clk);
        cfg_we = 0; cfg_len_we = 0;
        if (we) mdl_tbl[a] = W'(d);
        if (lwe) mdl_len = l;
    endtask

    task automatic test_reset();
        mdl_default();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({out, out_valid, busy, done, cfg_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_hold: got %b want 0", {out, out_valid, busy, done, cfg_err});
        end
        rst = 0;
        @(negedge clk);
        n_chk++;
        if ({out, out_valid, busy, done, cfg_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_release: got %b want 0", {out, out_valid, busy, done, cfg_err});
        end
    endtask

    task automatic test_loops1();
        cap(1, 6, 0);
        for (int c = 0; c < 6; c++) begin
            n_chk++;
            if (q_obs[c] !== exp_at(c, 1, 0)) begin
                n_fail++; $display("FAIL loops1 cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 1, 0));
            end
        end
    endtask

    task automatic test_loops2();
        int nd = 0;
        cap(2, 10, 0);
        for (int c = 0; c < 10; c++) begin
            nd += int'(q_obs[c][1]);
            n_chk++;
            if (q_obs[c] !== exp_at(c, 2, 0)) begin
                n_fail++; $display("FAIL loops2 cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 2, 0));
            end
        end
        n_chk++;
        if (nd != 1) begin n_fail++; $display("FAIL loops2_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_cfg_table();
        cfg_wr(1, 0, 3'b111, 0, 0);
        cfg_wr(1, 1, 3'b001, 1, 2);
        n_chk++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_ok_no_err: got %b want 0", cfg_err); end
        cfg_wr(1, 2, 3'b100, 0, 0);
        cap(3, 11, 0);
        for (int c = 0; c < 11; c++) begin
            n_chk++;
            if (q_obs[c] !== exp_at(c, 3, 0)) begin
                n_fail++; $display("FAIL cfg_table cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 3, 0));
            end
        end
    endtask

    task automatic test_forever_halt();
        int nd = 0;
        cap(0, 24, 22);
        for (int c = 0; c < 24; c++) begin
            nd += int'(q_obs[c][1]);
            n_chk++;
            if (q_obs[c] !== exp_at(c, 0, 22)) begin
                n_fail++; $display("FAIL forever22 cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 0, 22));
            end
        end
        cap(0, 9, 7);
        for (int c = 0; c < 9; c++) begin
            nd += int'(q_obs[c][1]);
            n_chk++;
            if (q_obs[c] !== exp_at(c, 0, 7)) begin
                n_fail++; $display("FAIL halt7 cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 0, 7));
            end
        end
        n_chk++;
        if (nd != 0) begin n_fail++; $display("FAIL forever_done_count: got %0d want 0", nd); end
    endtask

    task automatic test_cfg_err();
        @(negedge clk); start = 1; loops = 8'd2;
        @(negedge clk); start = 0;
        cfg_we = 1; cfg_addr = 0; cfg_data = 3'b010; cfg_len_we = 1; cfg_len = 1;
        @(negedge clk); cfg_we = 0; cfg_len_we = 0;
        n_chk++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_run: got %b want 1", cfg_err); end
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
        repeat (8) @(negedge clk);
        start = 1; loops = 8'd1; cfg_we = 1; cfg_addr = 1; cfg_data = 3'b000;
        @(negedge clk); start = 0; cfg_we = 0;
        n_chk++;
        if ({cfg_err, busy, out} !== {2'b11, mdl_tbl[0]}) begin
            n_fail++; $display("FAIL cfg_err_start: got %b want %b", {cfg_err, busy, out}, {2'b11, mdl_tbl[0]});
        end
        repeat (5) @(negedge clk);
        cap(1, mdl_len + 3, 0);
        for (int c = 0; c < mdl_len + 3; c++) begin
            n_chk++;
            if (q_obs[c] !== exp_at(c, 1, 0)) begin
                n_fail++; $display("FAIL cfg_readback cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 1, 0));
            end
        end
    endtask

    task automatic test_len0();
        cfg_wr(0, 0, 0, 1, 0);
        cap(4, 6, 0);
        for (int c = 0; c < 6; c++) begin
            n_chk++;
            if (q_obs[c] !== exp_at(c, 4, 0)) begin
                n_fail++; $display("FAIL len0 cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 4, 0));
            end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); start = 1; loops = 8'd0;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        n_chk++;
        if ({out, out_valid, busy, done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_midrun: got %b want 0", {out, out_valid, busy, done});
        end
        @(negedge clk); rst = 0;
        mdl_default();
        cap(1, 6, 0);
        for (int c = 0; c < 6; c++) begin
            n_chk++;
            if (q_obs[c] !== exp_at(c, 1, 0)) begin
                n_fail++; $display("FAIL post_reset cyc%0d: got %b want %b", c, q_obs[c], exp_at(c, 1, 0));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 15; k++) begin
            int nw, L, h, n;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++)
                cfg_wr(1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)), 0, 0);
            cfg_wr(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, 7)), 1, int'($urandom_range(0, DEPTH - 1)));
            L = int'($urandom_range(1, 3));
            h = 0;
            if ($urandom_range(0, 3) == 0 && L * (mdl_len + 1) > 1)
                h = int'($urandom_range(1, L * (mdl_len + 1) - 1));
            n = L * (mdl_len + 1) + 2;
            cap(L, n, h);
            for (int c = 0; c < n; c++) begin
                n_chk++;
                if (q_obs[c] !== exp_at(c, L, h)) begin
                    n_fail++; $display("FAIL rand%0d cyc%0d: got %b want %b", k, c, q_obs[c], exp_at(c, L, h));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loops1();
        test_loops2();
        test_cfg_table();
        test_forever_halt();
        test_cfg_err();
        test_len0();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
